// File: rtl/cp0_regs_if.sv
// Pipeline-facing bundle of the CP0 register file: mfc0/mtc0 bus, exception commit,
// eret, hardware interrupt lines and the live Status/Cause/EPC/interrupt outputs.
interface cp0_regs_if #(
    parameter int HW_INT_W = 6
);
    logic [HW_INT_W-1:0] hw_int;
    logic [4:0]          rd_addr;
    logic [31:0]         rd_data;
    logic                wr_en;
    logic [4:0]          wr_addr;
    logic [31:0]         wr_data;
    logic                exc_we;
    logic [4:0]          exc_code;
    logic                exc_bd;
    logic [31:0]         exc_epc;
    logic [31:0]         exc_bva;
    logic                eret;
    logic [31:0]         epc;
    logic [31:0]         status;
    logic [31:0]         cause;
    logic [7:0]          intr_vect;

    modport master (
        output hw_int, rd_addr, wr_en, wr_addr, wr_data,
               exc_we, exc_code, exc_bd, exc_epc, exc_bva, eret,
        input  rd_data, epc, status, cause, intr_vect
    );

    modport slave (
        input  hw_int, rd_addr, wr_en, wr_addr, wr_data,
               exc_we, exc_code, exc_bd, exc_epc, exc_bva, eret,
        output rd_data, epc, status, cause, intr_vect
    );
endinterface

// File: rtl/cp0_regs.sv
// CP0 register file: BadVAddr, Count/Compare timer, Status, Cause, EPC, with
// exception commit, eret and masked interrupt vector generation.
module cp0_regs #(
    parameter int COUNT_DIV = 2,
    parameter int HW_INT_W  = 6
) (
    input logic         clk,
    input logic         rst,
    cp0_regs_if.slave   bus
);
    localparam int DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);

    localparam logic [4:0] A_BADVADDR = 5'd8;
    localparam logic [4:0] A_COUNT    = 5'd9;
    localparam logic [4:0] A_COMPARE  = 5'd11;
    localparam logic [4:0] A_STATUS   = 5'd12;
    localparam logic [4:0] A_CAUSE    = 5'd13;
    localparam logic [4:0] A_EPC      = 5'd14;

    logic [31:0]         badvaddr_q;
    logic [31:0]         count_q;
    logic [31:0]         compare_q;
    logic [31:0]         epc_q;
    logic [DIV_W-1:0]    div_q;
    logic [7:0]          im_q;
    logic                exl_q;
    logic                ie_q;
    logic                bd_q;
    logic                ti_q;
    logic [4:0]          code_q;
    logic [1:0]          sw_q;
    logic [HW_INT_W-1:0] hw_q;
    logic [5:0]          hw_ip;

    logic        wr_act;
    logic        wr_count;
    logic        wr_compare;
    logic        wr_status;
    logic        tick;
    logic [31:0] count_inc;
    logic [7:0]  ip;
    logic [31:0] status_val;
    logic [31:0] cause_val;

    generate
        if (HW_INT_W >= 6) begin : g_hw_trunc
            assign hw_ip = hw_q[5:0];
        end else begin : g_hw_ext
            assign hw_ip = {{(6 - HW_INT_W){1'b0}}, hw_q};
        end
    endgenerate

    // A committing exception swallows any mtc0 issued in the same cycle.
    assign wr_act     = bus.wr_en & ~bus.exc_we;
    assign wr_count   = wr_act && (bus.wr_addr == A_COUNT);
    assign wr_compare = wr_act && (bus.wr_addr == A_COMPARE);
    assign wr_status  = wr_act && (bus.wr_addr == A_STATUS);
    assign tick       = (div_q == DIV_LAST);
    assign count_inc  = count_q + 32'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            badvaddr_q <= '0;
            count_q    <= '0;
            compare_q  <= '0;
            epc_q      <= '0;
            div_q      <= '0;
            im_q       <= '0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ti_q       <= 1'b0;
            code_q     <= '0;
            sw_q       <= '0;
            hw_q       <= '0;
        end else begin
            hw_q <= bus.hw_int;

            if (wr_count) begin
                count_q <= bus.wr_data;
                div_q   <= '0;
            end else if (tick) begin
                count_q <= count_inc;
                div_q   <= '0;
            end else begin
                div_q <= div_q + DIV_W'(1);
            end

            // Only a real increment landing on Compare raises TI; a Compare write clears it first.
            if (wr_compare) begin
                compare_q <= bus.wr_data;
                ti_q      <= 1'b0;
            end else if (tick && !wr_count && (count_inc == compare_q)) begin
                ti_q <= 1'b1;
            end

            if (wr_status) begin
                im_q <= bus.wr_data[15:8];
                ie_q <= bus.wr_data[0];
            end

            if (bus.exc_we)
                exl_q <= 1'b1;
            else if (bus.eret)
                exl_q <= 1'b0;
            else if (wr_status)
                exl_q <= bus.wr_data[1];

            if (wr_act && (bus.wr_addr == A_CAUSE))
                sw_q <= bus.wr_data[9:8];

            if (bus.exc_we) begin
                epc_q  <= bus.exc_epc;
                bd_q   <= bus.exc_bd;
                code_q <= bus.exc_code;
                if ((bus.exc_code == 5'd4) || (bus.exc_code == 5'd5))
                    badvaddr_q <= bus.exc_bva;
            end else begin
                if (wr_act && (bus.wr_addr == A_EPC))
                    epc_q <= bus.wr_data;
                if (wr_act && (bus.wr_addr == A_BADVADDR))
                    badvaddr_q <= bus.wr_data;
            end
        end
    end

    assign ip         = {hw_ip[5] | ti_q, hw_ip[4:0], sw_q};
    assign status_val = {9'd0, 1'b1, 6'd0, im_q, 6'd0, exl_q, ie_q};
    assign cause_val  = {bd_q, ti_q, 14'd0, ip, 1'b0, code_q, 2'b00};

    always_comb begin
        bus.rd_data = '0;
        case (bus.rd_addr)
            A_BADVADDR: bus.rd_data = badvaddr_q;
            A_COUNT:    bus.rd_data = count_q;
            A_COMPARE:  bus.rd_data = compare_q;
            A_STATUS:   bus.rd_data = status_val;
            A_CAUSE:    bus.rd_data = cause_val;
            A_EPC:      bus.rd_data = epc_q;
            default:    bus.rd_data = '0;
        endcase
    end

    assign bus.epc       = epc_q;
    assign bus.status    = status_val;
    assign bus.cause     = cause_val;
    assign bus.intr_vect = (ie_q && !exl_q) ? (ip & im_q) : 8'h00;
endmodule

// File: tb/tb_cp0_regs.sv
// Self-checking bench for cp0_regs: directed scenarios plus randomized traffic
// compared against a behavioural model of the CP0 registers.
module tb_cp0_regs;
    localparam int COUNT_DIV = 2;
    localparam int HW_INT_W  = 6;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    cp0_regs_if #(.HW_INT_W(HW_INT_W)) bus ();

    cp0_regs #(.COUNT_DIV(COUNT_DIV), .HW_INT_W(HW_INT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model state
    bit [31:0] m_badva, m_count, m_compare, m_epc;
    int        m_div;
    bit [7:0]  m_im;
    bit        m_exl, m_ie, m_bd, m_ti;
    bit [4:0]  m_code;
    bit [5:0]  m_hw;
    bit [1:0]  m_sw;

    task automatic model_reset();
        m_badva = 0; m_count = 0; m_compare = 0; m_epc = 0; m_div = 0;
        m_im = 0; m_exl = 0; m_ie = 0; m_bd = 0; m_ti = 0; m_code = 0;
        m_hw = 0; m_sw = 0;
    endtask

    function automatic bit [7:0] exp_ip();
        return {m_hw[5] | m_ti, m_hw[4:0], m_sw};
    endfunction

    function automatic bit [31:0] exp_status();
        return 32'h0040_0000 | (32'(m_im) << 8) | (32'(m_exl) << 1) | 32'(m_ie);
    endfunction

    function automatic bit [31:0] exp_cause();
        return (32'(m_bd) << 31) | (32'(m_ti) << 30) | (32'(exp_ip()) << 8) | (32'(m_code) << 2);
    endfunction

    function automatic bit [7:0] exp_intr();
        return (m_ie && !m_exl) ? (exp_ip() & m_im) : 8'h00;
    endfunction

    function automatic bit [31:0] exp_read(input bit [4:0] a);
        case (a)
            5'd8:    return m_badva;
            5'd9:    return m_count;
            5'd11:   return m_compare;
            5'd12:   return exp_status();
            5'd13:   return exp_cause();
            5'd14:   return m_epc;
            default: return 32'h0;
        endcase
    endfunction

    // Advance the model by one clock from the inputs currently presented.
    task automatic model_step();
        bit        wr;
        bit [31:0] d;
        bit [4:0]  a;
        bit [31:0] old_count;
        old_count = m_count;
        wr = bus.wr_en && !bus.exc_we;
        d  = bus.wr_data;
        a  = bus.wr_addr;
        if (wr && a == 5'd9) begin
            m_count = d;
            m_div   = 0;
        end else if (m_div == COUNT_DIV - 1) begin
            m_div   = 0;
            m_count = old_count + 1;
            if (m_count == m_compare) m_ti = 1;
        end else begin
            m_div = m_div + 1;
        end
        if (wr && a == 5'd11) begin
            m_compare = d;
            m_ti      = 0;
        end
        if (wr && a == 5'd12) begin
            m_im  = d[15:8];
            m_ie  = d[0];
            m_exl = d[1];
        end
        if (bus.eret) m_exl = 0;
        if (wr && a == 5'd13) m_sw = d[9:8];
        if (wr && a == 5'd14) m_epc = d;
        if (wr && a == 5'd8) m_badva = d;
        if (bus.exc_we) begin
            m_exl  = 1;
            m_epc  = bus.exc_epc;
            m_bd   = bus.exc_bd;
            m_code = bus.exc_code;
            if (bus.exc_code == 5'd4 || bus.exc_code == 5'd5) m_badva = bus.exc_bva;
        end
        m_hw = bus.hw_int;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0;
        bus.exc_we = 0; bus.exc_code = 0; bus.exc_bd = 0; bus.exc_epc = 0; bus.exc_bva = 0;
        bus.eret = 0;
    endtask

    task automatic mtc0(input bit [4:0] a, input bit [31:0] d);
        bus.wr_en = 1; bus.wr_addr = a; bus.wr_data = d;
        step();
        bus.wr_en = 0;
    endtask

    task automatic exc(input bit [4:0] code, input bit bd, input bit [31:0] pc, input bit [31:0] bva);
        bus.exc_we = 1; bus.exc_code = code; bus.exc_bd = bd; bus.exc_epc = pc; bus.exc_bva = bva;
        step();
        bus.exc_we = 0;
    endtask

    task automatic read_reg(input bit [4:0] a, output bit [31:0] d);
        bus.rd_addr = a;
        #1;
        d = bus.rd_data;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        bus.hw_int = 0;
        bus.rd_addr = 0;
        rst = 1;
        model_reset();
        #2;
        rst = 0;
        step();
    endtask

    task automatic test_reset();
        bit [31:0] d;
        do_reset();
        bus.hw_int = 6'h01;
        exc(5'd0, 1'b1, 32'h8000_1000, 32'h0);
        bus.eret = 1; step(); bus.eret = 0;
        mtc0(5'd12, 32'h0000_0401);
        mtc0(5'd9, 32'h0000_0010);
        n_checks++;
        read_reg(5'd9, d);
        if (d !== 32'h10 || bus.intr_vect !== 8'h04) begin
            n_errors++;
            $display("FAIL pre_reset count=%h intr=%h required count=00000010 intr=04", d, bus.intr_vect);
        end
        rst = 1;
        model_reset();
        #1;
        n_checks++;
        read_reg(5'd9, d);
        if (d !== 32'h0 || bus.epc !== 32'h0 || bus.cause !== 32'h0 ||
            bus.intr_vect !== 8'h0 || bus.status !== 32'h0040_0000) begin
            n_errors++;
            $display("FAIL reset_immediate count=%h epc=%h cause=%h intr=%h status=%h required 0/0/0/0/00400000",
                     d, bus.epc, bus.cause, bus.intr_vect, bus.status);
        end
        #1;
        rst = 0;
        bus.hw_int = 0;
        step();
    endtask

    task automatic test_exception();
        bit [31:0] d;
        do_reset();
        exc(5'd4, 1'b1, 32'hBFC0_0104, 32'h0000_0003);
        n_checks++;
        read_reg(5'd8, d);
        if (bus.epc !== 32'hBFC0_0104 || bus.cause !== 32'h8000_0010 || d !== 32'h3 ||
            bus.status !== 32'h0040_0002) begin
            n_errors++;
            $display("FAIL exc_ades epc=%h cause=%h badva=%h status=%h required bfc00104/80000010/00000003/00400002",
                     bus.epc, bus.cause, d, bus.status);
        end
        exc(5'd12, 1'b0, 32'h8000_0200, 32'hDEAD_BEEF);
        n_checks++;
        read_reg(5'd8, d);
        if (d !== 32'h3 || bus.cause !== 32'h0000_0030 || bus.epc !== 32'h8000_0200) begin
            n_errors++;
            $display("FAIL exc_ov badva=%h cause=%h epc=%h required 00000003/00000030/80000200", d, bus.cause, bus.epc);
        end
    endtask

    task automatic test_status_eret();
        bit [31:0] d;
        mtc0(5'd12, 32'hFFFF_FFFF);
        n_checks++;
        read_reg(5'd12, d);
        if (bus.status !== 32'h0040_FF03 || d !== 32'h0040_FF03) begin
            n_errors++;
            $display("FAIL status_mask status=%h rd=%h required 0040ff03", bus.status, d);
        end
        bus.eret = 1; step(); bus.eret = 0;
        n_checks++;
        if (bus.status !== 32'h0040_FF01) begin
            n_errors++;
            $display("FAIL eret status=%h required 0040ff01", bus.status);
        end
    endtask

    task automatic test_timer();
        int rise;
        bit [31:0] d;
        do_reset();
        mtc0(5'd12, 32'h0000_8001);
        mtc0(5'd11, 32'd5);
        mtc0(5'd9, 32'd0);
        rise = -1;
        for (int i = 1; i <= 20; i++) begin
            step();
            n_checks++;
            if (bus.cause[30] !== m_ti || bus.intr_vect !== exp_intr()) begin
                n_errors++;
                $display("FAIL timer_cycle%0d ti=%b intr=%h required ti=%b intr=%h",
                         i, bus.cause[30], bus.intr_vect, m_ti, exp_intr());
            end
            if (bus.cause[30] === 1'b1 && rise < 0) rise = i;
        end
        n_checks++;
        if (rise != 10) begin
            n_errors++;
            $display("FAIL timer_rise cycle=%0d required 10", rise);
        end
        n_checks++;
        if (bus.intr_vect !== 8'h80 || bus.cause[15] !== 1'b1) begin
            n_errors++;
            $display("FAIL timer_intr intr=%h ip7=%b required 80/1", bus.intr_vect, bus.cause[15]);
        end
        mtc0(5'd11, 32'h100);
        n_checks++;
        if (bus.cause[30] !== 1'b0 || bus.intr_vect !== 8'h00) begin
            n_errors++;
            $display("FAIL timer_clear ti=%b intr=%h required 0/00", bus.cause[30], bus.intr_vect);
        end
        // Compare write coinciding with the increment that would hit Compare
        mtc0(5'd11, 32'd5);
        mtc0(5'd9, 32'd4);
        step();
        mtc0(5'd11, 32'd5);
        n_checks++;
        read_reg(5'd9, d);
        if (d !== 32'd5 || bus.cause[30] !== 1'b0) begin
            n_errors++;
            $display("FAIL timer_clear_wins count=%h ti=%b required 00000005/0", d, bus.cause[30]);
        end
        mtc0(5'd9, 32'd5);
        n_checks++;
        if (bus.cause[30] !== 1'b0) begin
            n_errors++;
            $display("FAIL timer_load_equal ti=%b required 0", bus.cause[30]);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        bus.wr_en = 1; bus.wr_addr = 5'd14; bus.wr_data = 32'h1234;
        exc(5'd8, 1'b0, 32'h8000_0ABC, 32'h0);
        bus.wr_en = 0;
        n_checks++;
        if (bus.epc !== 32'h8000_0ABC) begin
            n_errors++;
            $display("FAIL exc_over_mtc0 epc=%h required 80000abc", bus.epc);
        end
        bus.eret = 1;
        exc(5'd9, 1'b0, 32'h8000_0100, 32'h0);
        bus.eret = 0;
        n_checks++;
        if (bus.status[1] !== 1'b1) begin
            n_errors++;
            $display("FAIL exc_over_eret exl=%b required 1", bus.status[1]);
        end
        bus.eret = 1;
        mtc0(5'd12, 32'h0000_1203);
        bus.eret = 0;
        n_checks++;
        if (bus.status !== 32'h0040_1201) begin
            n_errors++;
            $display("FAIL eret_over_mtc0 status=%h required 00401201", bus.status);
        end
    endtask

    task automatic test_intr_gating();
        do_reset();
        mtc0(5'd12, 32'h0000_0401);
        bus.hw_int = 6'h01;
        #1;
        n_checks++;
        if (bus.intr_vect !== 8'h00) begin
            n_errors++;
            $display("FAIL hw_latency intr=%h required 00", bus.intr_vect);
        end
        step();
        n_checks++;
        if (bus.intr_vect !== 8'h04) begin
            n_errors++;
            $display("FAIL hw_int0 intr=%h required 04", bus.intr_vect);
        end
        mtc0(5'd12, 32'h0000_0403);
        n_checks++;
        if (bus.intr_vect !== 8'h00) begin
            n_errors++;
            $display("FAIL exl_gate intr=%h required 00", bus.intr_vect);
        end
        bus.hw_int = 0;
        step();
    endtask

    task automatic test_count_wrap();
        bit [31:0] d;
        mtc0(5'd9, 32'hFFFF_FFFF);
        for (int i = 0; i < COUNT_DIV - 1; i++) step();
        n_checks++;
        read_reg(5'd9, d);
        if (d !== 32'hFFFF_FFFF) begin
            n_errors++;
            $display("FAIL wrap_hold count=%h required ffffffff", d);
        end
        step();
        n_checks++;
        read_reg(5'd9, d);
        if (d !== 32'h0) begin
            n_errors++;
            $display("FAIL wrap_zero count=%h required 00000000", d);
        end
    endtask

    task automatic test_random();
        bit [4:0] addrs [8];
        addrs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0, 5'd15};
        do_reset();
        for (int i = 0; i < 400; i++) begin
            bus.hw_int  = 6'($urandom);
            bus.rd_addr = ($urandom_range(0, 3) == 0) ? 5'($urandom) : addrs[$urandom_range(0, 7)];
            bus.wr_en   = ($urandom_range(0, 1) == 1);
            bus.wr_addr = addrs[$urandom_range(0, 7)];
            bus.wr_data = $urandom;
            if (bus.wr_addr == 5'd11) bus.wr_data = m_count + 32'($urandom_range(0, 4));
            if (bus.wr_addr == 5'd12 && $urandom_range(0, 1) == 1) bus.wr_data = bus.wr_data & 32'hFFFF_FFFD;
            bus.exc_we   = ($urandom_range(0, 7) == 0);
            bus.exc_code = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(4, 5)) : 5'($urandom);
            bus.exc_bd   = 1'($urandom);
            bus.exc_epc  = $urandom;
            bus.exc_bva  = $urandom;
            bus.eret     = ($urandom_range(0, 5) == 0);
            step();
            n_checks++;
            if (bus.rd_data !== exp_read(bus.rd_addr) || bus.epc !== m_epc || bus.status !== exp_status() ||
                bus.cause !== exp_cause() || bus.intr_vect !== exp_intr()) begin
                n_errors++;
                $display("FAIL random_%0d rd[%0d]=%h epc=%h status=%h cause=%h intr=%h required %h/%h/%h/%h/%h",
                         i, bus.rd_addr, bus.rd_data, bus.epc, bus.status, bus.cause, bus.intr_vect,
                         exp_read(bus.rd_addr), m_epc, exp_status(), exp_cause(), exp_intr());
            end
        end
        idle();
    endtask

    initial begin
        idle();
        bus.hw_int  = 0;
        bus.rd_addr = 0;
        model_reset();
        test_reset();
        test_exception();
        test_status_eret();
        test_timer();
        test_simultaneous();
        test_intr_gating();
        test_count_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
